// File: rtl/fix_pkg.sv
// ----------------------------------------------------------------------------
// fix_pkg
//
// Shared fixed-point helpers for the MNIST inference datapath. The multiplier,
// adder and MAC blocks all saturate symmetrically, so the legal range of a
// WIDTH-bit two's complement value is [-(2^(WIDTH-1)-1), 2^(WIDTH-1)-1].
// The most negative code 100...0 is never produced by any of these blocks.
//
// Contents:
//   FIX4_WIDTH / FIX4_FRAC_BITS  default operand format (4-bit integer)
//   fix4_t                       signed type for the default format
//   sat_max(width)               largest legal value for a given width
//   sat_clamp(value, width)      symmetric clamp of a wide value (width <= 31)
// ----------------------------------------------------------------------------
package fix_pkg;

    localparam int FIX4_WIDTH     = 4;
    localparam int FIX4_FRAC_BITS = 0;

    typedef logic signed [FIX4_WIDTH-1:0] fix4_t;

    // Largest representable magnitude; the negative limit is its negation.
    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Clamp a wide signed value into the symmetric range of 'width' bits.
    function automatic longint sat_clamp(input longint value, input int width);
        longint max_v;
        max_v = longint'(sat_max(width));
        if (value > max_v) begin
            return max_v;
        end
        if (value < -max_v) begin
            return -max_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/sat_mul_clamp.sv
// ----------------------------------------------------------------------------
// sat_clamp_comb
//
// Purely combinational symmetric saturator. Takes a 2*WIDTH-bit signed value
// (a scaled product) and narrows it to WIDTH bits, clamping to +/-MAX where
// MAX = 2^(WIDTH-1)-1.
//
// Ports:
//   value   in   2*WIDTH  signed wide value to narrow
//   result  out  WIDTH    clamped / truncated result
//   sat     out  1        high when either clamp fired
// ----------------------------------------------------------------------------
module sat_clamp_comb
    import fix_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic signed [2*WIDTH-1:0] value,
    output logic signed [WIDTH-1:0]   result,
    output logic                      sat
);

    // Limits expressed at the wide width so the comparisons are exact.
    localparam logic signed [2*WIDTH-1:0] MAX_WIDE = (2*WIDTH)'(sat_max(WIDTH));
    localparam logic signed [2*WIDTH-1:0] MIN_WIDE = -MAX_WIDE;

    // The same limits at the output width.
    localparam logic signed [WIDTH-1:0] MAX_NARROW = MAX_WIDE[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] MIN_NARROW = MIN_WIDE[WIDTH-1:0];

    // In range, the low WIDTH bits already hold the correct two's complement
    // value, so plain truncation is enough; only out-of-range values clamp.
    always_comb begin
        result = value[WIDTH-1:0];
        sat    = 1'b0;
        if (value > MAX_WIDE) begin
            result = MAX_NARROW;
            sat    = 1'b1;
        end else if (value < MIN_WIDE) begin
            result = MIN_NARROW;
            sat    = 1'b1;
        end
    end

endmodule

// File: rtl/sat_mul.sv
// ----------------------------------------------------------------------------
// sat_mul
//
// Signed fixed-point multiplier with symmetric saturation. Used as the
// weight x activation primitive of the MNIST inference datapath.
//
// The combinational result 'o' is available for use inside larger
// combinational MAC paths; a registered copy with a valid strobe and
// saturation status serves pipelined users.
//
// Parameters:
//   WIDTH      operand/result width, two's complement, >= 2
//   FRAC_BITS  fractional bits per operand, 0 <= FRAC_BITS < WIDTH
//
// Ports:
//   clk         in   1      rising-edge clock for the registered outputs
//   rst         in   1      asynchronous active-high reset
//   a           in   WIDTH  signed multiplicand
//   b           in   WIDTH  signed multiplier
//   in_valid    in   1      qualifies a/b for the registered path
//   sat_clr     in   1      synchronous clear of sat_sticky
//   o           out  WIDTH  combinational saturated product
//   o_q         out  WIDTH  registered o (updates only when in_valid)
//   out_valid   out  1      registered in_valid
//   sat_q       out  1      registered "this result was clamped"
//   sat_sticky  out  1      set on any clamped valid result, held until clear
// ----------------------------------------------------------------------------
module sat_mul
    import fix_pkg::*;
#(
    parameter int WIDTH     = FIX4_WIDTH,
    parameter int FRAC_BITS = FIX4_FRAC_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    in_valid,
    input  logic                    sat_clr,
    output logic signed [WIDTH-1:0] o,
    output logic signed [WIDTH-1:0] o_q,
    output logic                    out_valid,
    output logic                    sat_q,
    output logic                    sat_sticky
);

    localparam logic signed [2*WIDTH-1:0] MAX_WIDE   = (2*WIDTH)'(sat_max(WIDTH));
    localparam logic signed [2*WIDTH-1:0] MIN_WIDE   = -MAX_WIDE;
    localparam logic signed [WIDTH-1:0]   MIN_NARROW = MIN_WIDE[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0]   MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0]   a_cond;
    logic signed [WIDTH-1:0]   b_cond;
    logic signed [2*WIDTH-1:0] a_wide;
    logic signed [2*WIDTH-1:0] b_wide;
    logic signed [2*WIDTH-1:0] product;
    logic signed [2*WIDTH-1:0] scaled;
    logic                      sat;

    // The asymmetric code 100...0 is folded onto MIN so every operand lies in
    // the symmetric range; this keeps the product commutative and means the
    // clamp never has to deal with -2^(WIDTH-1) * -2^(WIDTH-1) corner cases.
    always_comb begin
        a_cond = (a == MOST_NEG) ? MIN_NARROW : a;
        b_cond = (b == MOST_NEG) ? MIN_NARROW : b;
    end

    // Sign-extend to double width so the full product always fits, then
    // rescale with an arithmetic (floor) shift. A zero operand yields an exact
    // zero product, which the clamp passes through with sat low.
    always_comb begin
        a_wide  = {{WIDTH{a_cond[WIDTH-1]}}, a_cond};
        b_wide  = {{WIDTH{b_cond[WIDTH-1]}}, b_cond};
        product = a_wide * b_wide;
        scaled  = product >>> FRAC_BITS;
    end

    sat_clamp_comb #(
        .WIDTH (WIDTH)
    ) u_clamp (
        .value  (scaled),
        .result (o),
        .sat    (sat)
    );

    // Registered result path. o_q/sat_q only update on valid inputs so a
    // downstream consumer can sample them at leisure after out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q       <= '0;
            sat_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                o_q   <= o;
                sat_q <= sat;
            end
        end
    end

    // Sticky saturation flag; a clear in the same cycle as a new clamped
    // result wins so software always observes the clear taking effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_sticky <= 1'b0;
        end else if (sat_clr) begin
            sat_sticky <= 1'b0;
        end else if (in_valid && sat) begin
            sat_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sat_mul.sv
// ----------------------------------------------------------------------------
// tb_sat_mul
//
// Directed bench for sat_mul. Two instances: the default 4-bit integer
// configuration (full combinational and registered behaviour) and an 8-bit
// Q4.4 configuration for the fractional scaling cases.
// ----------------------------------------------------------------------------
module tb_sat_mul;

    logic clk;
    logic rst;

    // Default 4-bit integer instance.
    logic signed [3:0] a4;
    logic signed [3:0] b4;
    logic              in_valid4;
    logic              sat_clr4;
    logic signed [3:0] o4;
    logic signed [3:0] o_q4;
    logic              out_valid4;
    logic              sat_q4;
    logic              sat_sticky4;

    // 8-bit Q4.4 instance, combinational checks only.
    logic signed [7:0] a8;
    logic signed [7:0] b8;
    logic              in_valid8;
    logic              sat_clr8;
    logic signed [7:0] o8;
    logic signed [7:0] o_q8;
    logic              out_valid8;
    logic              sat_q8;
    logic              sat_sticky8;

    int vectors;
    int miscompares;

    sat_mul dut4 (
        .clk        (clk),
        .rst        (rst),
        .a          (a4),
        .b          (b4),
        .in_valid   (in_valid4),
        .sat_clr    (sat_clr4),
        .o          (o4),
        .o_q        (o_q4),
        .out_valid  (out_valid4),
        .sat_q      (sat_q4),
        .sat_sticky (sat_sticky4)
    );

    sat_mul #(
        .WIDTH     (8),
        .FRAC_BITS (4)
    ) dut8 (
        .clk        (clk),
        .rst        (rst),
        .a          (a8),
        .b          (b8),
        .in_valid   (in_valid8),
        .sat_clr    (sat_clr8),
        .o          (o8),
        .o_q        (o_q8),
        .out_valid  (out_valid8),
        .sat_q      (sat_q8),
        .sat_sticky (sat_sticky8)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the 4-bit instance inputs with blocking assignments.
    task automatic applyStimulus(input int av, input int bv, input logic valid, input logic clr);
        a4        = 4'(av);
        b4        = 4'(bv);
        in_valid4 = valid;
        sat_clr4  = clr;
    endtask

    // One comparison; values are sign-extended so X/Z still miscompare.
    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance through one rising edge and settle just after it.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Reference for the 4-bit integer case: fold -8 to -7, multiply, clamp.
    function automatic int refMul4(input int av, input int bv);
        int x;
        int y;
        int p;
        x = (av == -8) ? -7 : av;
        y = (bv == -8) ? -7 : bv;
        p = x * y;
        if (p > 7) p = 7;
        if (p < -7) p = -7;
        return p;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        a8          = '0;
        b8          = '0;
        in_valid8   = 1'b0;
        sat_clr8    = 1'b0;
        applyStimulus(0, 0, 1'b0, 1'b0);

        // Reset state with no clock edge yet.
        #1;
        checkOutput("rst_o_q",        o_q4,        0);
        checkOutput("rst_out_valid",  out_valid4,  0);
        checkOutput("rst_sat_q",      sat_q4,      0);
        checkOutput("rst_sat_sticky", sat_sticky4, 0);

        // Release reset away from the rising edge.
        @(negedge clk);
        rst = 1'b0;

        // Directed combinational vectors.
        applyStimulus(2, 3, 1'b0, 1'b0);   #1; checkOutput("comb_2x3",   o4,  6);
        applyStimulus(3, 3, 1'b0, 1'b0);   #1; checkOutput("comb_3x3",   o4,  7);
        applyStimulus(-3, 3, 1'b0, 1'b0);  #1; checkOutput("comb_m3x3",  o4, -7);
        applyStimulus(-7, -7, 1'b0, 1'b0); #1; checkOutput("comb_m7xm7", o4,  7);
        applyStimulus(0, -7, 1'b0, 1'b0);  #1; checkOutput("comb_0xm7",  o4,  0);
        applyStimulus(-8, 1, 1'b0, 1'b0);  #1; checkOutput("comb_m8x1",  o4, -7);
        applyStimulus(-8, -1, 1'b0, 1'b0); #1; checkOutput("comb_m8xm1", o4,  7);
        applyStimulus(1, -8, 1'b0, 1'b0);  #1; checkOutput("comb_1xm8",  o4, -7);

        // All 256 operand pairs, including -8 on either side.
        for (int i = -8; i < 8; i++) begin
            for (int j = -8; j < 8; j++) begin
                applyStimulus(i, j, 1'b0, 1'b0);
                #1;
                checkOutput($sformatf("sweep_%0dx%0d", i, j), o4, refMul4(i, j));
            end
        end

        // Registered path: one-cycle latency, hold when not valid.
        @(negedge clk);
        applyStimulus(3, 2, 1'b1, 1'b0);
        stepEdge();
        checkOutput("reg_o_q",       o_q4,       6);
        checkOutput("reg_out_valid", out_valid4, 1);
        applyStimulus(5, 1, 1'b0, 1'b0);
        stepEdge();
        checkOutput("hold_o_q",       o_q4,       6);
        checkOutput("hold_out_valid", out_valid4, 0);

        // Sticky saturation behaviour.
        applyStimulus(4, 4, 1'b1, 1'b0);
        stepEdge();
        checkOutput("sat_4x4_o_q",    o_q4,        7);
        checkOutput("sat_4x4_sat_q",  sat_q4,      1);
        checkOutput("sat_4x4_sticky", sat_sticky4, 1);
        applyStimulus(1, 1, 1'b1, 1'b0);
        stepEdge();
        checkOutput("sat_1x1_o_q",    o_q4,        1);
        checkOutput("sat_1x1_sat_q",  sat_q4,      0);
        checkOutput("sat_1x1_sticky", sat_sticky4, 1);
        applyStimulus(0, 0, 1'b0, 1'b1);
        stepEdge();
        checkOutput("clr_sticky", sat_sticky4, 0);
        checkOutput("clr_sat_q",  sat_q4,      0);
        applyStimulus(5, 5, 1'b1, 1'b1);
        stepEdge();
        checkOutput("clr_wins_sticky", sat_sticky4, 0);
        checkOutput("clr_wins_sat_q",  sat_q4,      1);
        checkOutput("clr_wins_o_q",    o_q4,        7);

        // Async reset mid-stream: build state, then reset between edges.
        applyStimulus(4, 4, 1'b1, 1'b0);
        stepEdge();
        applyStimulus(3, 2, 1'b1, 1'b0);
        stepEdge();
        checkOutput("pre_rst_o_q",    o_q4,        6);
        checkOutput("pre_rst_sticky", sat_sticky4, 1);
        applyStimulus(2, 2, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_o_q",       o_q4,        0);
        checkOutput("async_rst_out_valid", out_valid4,  0);
        checkOutput("async_rst_sat_q",     sat_q4,      0);
        checkOutput("async_rst_sticky",    sat_sticky4, 0);
        stepEdge();
        checkOutput("rst_held_o_q",       o_q4,       0);
        checkOutput("rst_held_out_valid", out_valid4, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_o_q_before_edge", o_q4, 0);
        stepEdge();
        checkOutput("post_rst_o_q",       o_q4,       4);
        checkOutput("post_rst_out_valid", out_valid4, 1);
        applyStimulus(0, 0, 1'b0, 1'b0);

        // Q4.4 scaling: 1.5 * 2.0 = 3.0, then positive and negative clamps.
        a8 = 8'sh18; b8 = 8'sh20; #1; checkOutput("q44_1p5x2p0", o8, 48);    // 0x30
        a8 = 8'sh70; b8 = 8'sh70; #1; checkOutput("q44_sat_pos", o8, 127);   // 0x7F
        a8 = 8'sh90; b8 = 8'sh70; #1; checkOutput("q44_sat_neg", o8, -127);  // 0x81
        a8 = 8'sh80; b8 = 8'sh10; #1; checkOutput("q44_m8x1",    o8, -127);  // -128 folded
        a8 = 8'sh00; b8 = 8'sh7F; #1; checkOutput("q44_zero",    o8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
